// File: rtl/xbar_pkg.sv
// Shared constants and geometry helpers for the programmable routing crossbar.
package xbar_pkg;

  localparam int PROG_W   = 32;
  localparam int SEL_ZERO = 0;

  function automatic int sel_w(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  function automatic int fpw(input int sel_width);
    return PROG_W / sel_width;
  endfunction

  function automatic int prog_len(input int n_out, input int fields);
    return (n_out + fields - 1) / fields;
  endfunction

endpackage

// File: rtl/prog_xbar_if.sv
// Programming-chain bundle: upstream word in, downstream word out, status flags.
interface prog_xbar_if;
  import xbar_pkg::*;

  // prog_shft qualifies prog_i for exactly one clock edge; the chain never
  // back-pressures. prog_commit is a single-cycle request sampled on the same edge.
  logic [PROG_W-1:0] prog_i;
  logic              prog_shft;
  logic              prog_commit;
  logic [PROG_W-1:0] prog_o;
  logic              cfg_ok;
  logic              cfg_err;

  modport master (
    output prog_i, prog_shft, prog_commit,
    input  prog_o, cfg_ok, cfg_err
  );

  modport slave (
    input  prog_i, prog_shft, prog_commit,
    output prog_o, cfg_ok, cfg_err
  );

endinterface

// File: rtl/xbar_cfg_chain.sv
// Double-buffered configuration store: shadow shift chain with word counter,
// atomic commit into the active bank that drives routing.
module xbar_cfg_chain
  import xbar_pkg::*;
#(
  parameter int L = 7
) (
  input  logic                clk,
  input  logic                res,
  input  logic [PROG_W-1:0]   prog_i,
  input  logic                prog_shft,
  input  logic                prog_commit,
  output logic [PROG_W-1:0]   prog_o,
  output logic                cfg_ok,
  output logic                cfg_err,
  output logic [L*PROG_W-1:0] active_o
);

  localparam int               CNT_W    = $clog2(L + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

  logic [PROG_W-1:0] r_shadow [L];
  logic [PROG_W-1:0] r_active [L];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  always_ff @(posedge clk) begin
    if (res) begin
      for (int k = 0; k < L; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (prog_shft) begin
      r_shadow[0] <= prog_i;
      for (int k = 1; k < L; k++) r_shadow[k] <= r_shadow[k-1];
      // Saturate so pass-through words on a long daisy chain keep cfg_ok high.
      if (r_cnt != CNT_FULL) r_cnt <= r_cnt + CNT_W'(1);
      if (prog_commit) r_err <= 1'b1;
    end else if (prog_commit) begin
      if (r_cnt == CNT_FULL) begin
        for (int k = 0; k < L; k++) r_active[k] <= r_shadow[k];
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign prog_o  = r_shadow[L-1];
  assign cfg_ok  = (r_cnt == CNT_FULL);
  assign cfg_err = r_err;

  for (genvar k = 0; k < L; k++) begin : g_flat
    assign active_o[k*PROG_W +: PROG_W] = r_active[k];
  end

endmodule

// File: rtl/prog_xbar.sv
// Parametrised N_IN x N_OUT bit crossbar with per-output select fields
// loaded through the programming chain; optional registered output.
module prog_xbar
  import xbar_pkg::*;
#(
  parameter int N_IN    = 32,
  parameter int N_OUT   = 32,
  parameter int REG_OUT = 1
) (
  input  logic              clk,
  input  logic              res,
  prog_xbar_if.slave        prog,
  input  logic [N_IN-1:0]   data_i,
  output logic [N_OUT-1:0]  data_o
);

  localparam int SEL_W = sel_w(N_IN);
  localparam int FPW   = fpw(SEL_W);
  localparam int L     = prog_len(N_OUT, FPW);
  localparam int PAD_W = 2 ** SEL_W;

  logic [L*PROG_W-1:0] w_active;
  logic [PAD_W-1:0]    w_in_pad;
  logic [N_OUT-1:0]    w_route;
  logic                w_unused_bits;

  xbar_cfg_chain #(.L(L)) u_cfg (
    .clk         (clk),
    .res         (res),
    .prog_i      (prog.prog_i),
    .prog_shft   (prog.prog_shft),
    .prog_commit (prog.prog_commit),
    .prog_o      (prog.prog_o),
    .cfg_ok      (prog.cfg_ok),
    .cfg_err     (prog.cfg_err),
    .active_o    (w_active)
  );

  // Slot 0 and slots above N_IN read constant zero, so any select value decodes cleanly.
  always_comb begin
    w_in_pad         = '0;
    w_in_pad[N_IN:1] = data_i;
  end

  always_comb begin
    w_route = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_route[j] = w_in_pad[w_active[(j/FPW)*PROG_W + (j%FPW)*SEL_W +: SEL_W]];
    end
  end

  // Spare high bits of each word carry no select field.
  assign w_unused_bits = ^w_active;

  if (REG_OUT != 0) begin : g_reg
    logic [N_OUT-1:0] r_data;
    always_ff @(posedge clk) begin
      if (res) r_data <= '0;
      else     r_data <= w_route;
    end
    assign data_o = r_data;
  end else begin : g_comb
    assign data_o = w_route;
  end

endmodule

// File: tb/tb_prog_xbar.sv
// Directed bench for prog_xbar: default 32x32 registered instance plus a
// small 8x4 combinational instance, with a per-cycle data_o scoreboard.
module tb_prog_xbar;
  import xbar_pkg::*;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  data_i2;
  logic [3:0]  data_o2;

  always #5 clk = ~clk;

  prog_xbar_if u_if ();
  prog_xbar_if u_if2 ();

  prog_xbar #(.N_IN(32), .N_OUT(32), .REG_OUT(1)) u_dut (
    .clk    (clk),
    .res    (res),
    .prog   (u_if),
    .data_i (data_i),
    .data_o (data_o)
  );

  prog_xbar #(.N_IN(8), .N_OUT(4), .REG_OUT(0)) u_dut2 (
    .clk    (clk),
    .res    (res),
    .prog   (u_if2),
    .data_i (data_i2),
    .data_o (data_o2)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          m_sel[32];
  logic [31:0] ms[7];
  int          m_cnt;
  logic        m_err;
  int          cfg_sel[32];
  logic [31:0] cfg_w[7];
  logic [31:0] dw[9];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] route(input logic [31:0] din);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      if (m_sel[j] >= 1 && m_sel[j] <= 32) r[j] = din[m_sel[j]-1];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 7; k++) ms[k] = '0;
    for (int j = 0; j < 32; j++) m_sel[j] = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One clock: push the expected registered output, then compare after the edge.
  task automatic cycle();
    logic [31:0] e;
    if (res) exp_q.push_back(32'h0);
    else     exp_q.push_back(route(data_i));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("data_o", {32'h0, data_o}, {32'h0, e});
  endtask

  task automatic do_shift(input logic [31:0] word, input logic with_commit);
    u_if.prog_i      = word;
    u_if.prog_shft   = 1'b1;
    u_if.prog_commit = with_commit;
    cycle();
    u_if.prog_shft   = 1'b0;
    u_if.prog_commit = 1'b0;
    for (int k = 6; k >= 1; k--) ms[k] = ms[k-1];
    ms[0] = word;
    if (m_cnt < 7) m_cnt++;
    if (with_commit) m_err = 1'b1;
    chk("prog_o", {32'h0, u_if.prog_o}, {32'h0, ms[6]});
    chk("cfg_ok", {63'h0, u_if.cfg_ok}, {63'h0, (m_cnt == 7)});
    chk("cfg_err", {63'h0, u_if.cfg_err}, {63'h0, m_err});
  endtask

  task automatic do_commit();
    logic [31:0] w;
    u_if.prog_commit = 1'b1;
    cycle();
    u_if.prog_commit = 1'b0;
    if (m_cnt == 7) begin
      for (int j = 0; j < 32; j++) begin
        w = ms[j/5];
        m_sel[j] = int'(w[(j%5)*6 +: 6]);
      end
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    chk("commit_cfg_err", {63'h0, u_if.cfg_err}, {63'h0, m_err});
    chk("commit_cfg_ok", {63'h0, u_if.cfg_ok}, {63'h0, (m_cnt == 7)});
  endtask

  task automatic build_words();
    logic [31:0] w;
    logic [31:0] s;
    for (int k = 0; k < 7; k++) begin
      w = '0;
      for (int f = 0; f < 5; f++) begin
        if (k*5 + f < 32) begin
          s = cfg_sel[k*5 + f];
          w[f*6 +: 6] = s[5:0];
        end
      end
      cfg_w[k] = w;
    end
  endtask

  // Word for outputs 30..31 goes in first; word for outputs 0..4 goes in last.
  task automatic load_words(input int first, input int count);
    for (int i = 0; i < count; i++) do_shift(cfg_w[6-first-i], 1'b0);
  endtask

  task automatic clear_cfg();
    for (int j = 0; j < 32; j++) cfg_sel[j] = 0;
  endtask

  initial begin
    res = 1'b1;
    data_i = 32'hFFFF_FFFF;
    data_i2 = 8'h00;
    u_if.prog_i = '0;  u_if.prog_shft = 1'b0;  u_if.prog_commit = 1'b0;
    u_if2.prog_i = '0; u_if2.prog_shft = 1'b0; u_if2.prog_commit = 1'b0;
    model_reset();

    // Reset
    cycle();
    cycle();
    chk("rst_prog_o", {32'h0, u_if.prog_o}, 64'h0);
    chk("rst_cfg_ok", {63'h0, u_if.cfg_ok}, 64'h0);
    chk("rst_cfg_err", {63'h0, u_if.cfg_err}, 64'h0);
    chk("rst_data_o", {32'h0, data_o}, 64'h0);
    res = 1'b0;

    // Basic route: output0 <- select 4 (data_i[3])
    clear_cfg();
    cfg_sel[0] = 4;
    build_words();
    data_i = 32'h0000_0008;
    load_words(0, 7);
    chk("basic_cfg_ok", {63'h0, u_if.cfg_ok}, 64'h1);
    chk("basic_pre_commit", {32'h0, data_o}, 64'h0);
    do_commit();
    chk("basic_at_commit", {32'h0, data_o}, 64'h0);
    cycle();
    chk("basic_route", {32'h0, data_o}, 64'h1);

    // Short program: 5 words then commit is refused
    cfg_sel[0] = 6;
    build_words();
    load_words(0, 5);
    do_commit();
    chk("short_err", {63'h0, u_if.cfg_err}, 64'h1);
    chk("short_ok", {63'h0, u_if.cfg_ok}, 64'h0);
    cycle();
    chk("short_old_route", {32'h0, data_o}, 64'h1);
    load_words(5, 2);
    do_commit();
    chk("short_fix_err", {63'h0, u_if.cfg_err}, 64'h0);
    data_i = 32'h0000_0020;
    cycle();
    chk("short_new_route", {32'h0, data_o}, 64'h1);

    // Glitch-free reprogram: select 3 active, shift select 5 with live data
    cfg_sel[0] = 3;
    build_words();
    load_words(0, 7);
    do_commit();
    cfg_sel[0] = 5;
    build_words();
    for (int i = 0; i < 7; i++) begin
      data_i = $urandom;
      do_shift(cfg_w[6-i], 1'b0);
    end
    data_i = 32'h0000_0004;
    do_commit();
    chk("glitch_old_at_commit", {63'h0, data_o[0]}, 64'h1);
    data_i = 32'h0000_0010;
    cycle();
    chk("glitch_new_route", {63'h0, data_o[0]}, 64'h1);
    for (int i = 0; i < 6; i++) begin
      data_i = $urandom;
      cycle();
    end

    // Random full configuration across all outputs
    for (int j = 0; j < 32; j++) cfg_sel[j] = $urandom_range(0, 63);
    build_words();
    load_words(0, 7);
    do_commit();
    for (int i = 0; i < 10; i++) begin
      data_i = $urandom;
      cycle();
    end

    // Reset mid-shift drops the partial shadow and the active bank
    load_words(0, 3);
    res = 1'b1;
    cycle();
    model_reset();
    res = 1'b0;
    chk("midrst_prog_o", {32'h0, u_if.prog_o}, 64'h0);
    chk("midrst_cfg_ok", {63'h0, u_if.cfg_ok}, 64'h0);

    // Daisy chain pass-through and out-of-range selects
    for (int i = 0; i < 8; i++) dw[i] = $urandom;
    dw[8] = {2'b00, 6'd0, 6'd32, 6'd1, 6'd63, 6'd33};
    for (int i = 0; i < 9; i++) begin
      do_shift(dw[i], 1'b0);
      if (i == 6) chk("daisy_w0", {32'h0, u_if.prog_o}, {32'h0, dw[0]});
      if (i == 7) chk("daisy_w1", {32'h0, u_if.prog_o}, {32'h0, dw[1]});
    end
    chk("daisy_cfg_ok", {63'h0, u_if.cfg_ok}, 64'h1);
    do_commit();
    data_i = 32'hFFFF_FFFF;
    cycle();
    chk("sel_bounds", {59'h0, data_o[4:0]}, 64'h0C);

    // Commit together with shift is refused; routing unchanged
    for (int i = 0; i < 9; i++) dw[i] = $urandom;
    for (int i = 0; i < 8; i++) do_shift(dw[i], 1'b0);
    do_shift(dw[8], 1'b1);
    chk("shcommit_err", {63'h0, u_if.cfg_err}, 64'h1);
    cycle();
    chk("shcommit_route", {59'h0, data_o[4:0]}, 64'h0C);
    data_i = $urandom;
    cycle();

    // Small combinational instance: one word maps outputs 0..3 to inputs 0..3
    data_i2 = 8'hFF;
    u_if2.prog_i = 32'h0000_4321;
    u_if2.prog_shft = 1'b1;
    cycle();
    u_if2.prog_shft = 1'b0;
    chk("small_cfg_ok", {63'h0, u_if2.cfg_ok}, 64'h1);
    chk("small_pre_commit", {60'h0, data_o2}, 64'h0);
    u_if2.prog_commit = 1'b1;
    cycle();
    u_if2.prog_commit = 1'b0;
    chk("small_cfg_err", {63'h0, u_if2.cfg_err}, 64'h0);
    chk("small_at_commit", {60'h0, data_o2}, 64'hF);
    for (int i = 0; i < 4; i++) begin
      data_i2 = 8'($urandom);
      #1;
      chk("small_comb", {60'h0, data_o2}, {60'h0, data_i2[3:0]});
    end
    data_i2 = 8'h05;
    #1;
    chk("small_comb_fixed", {60'h0, data_o2}, 64'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_xbar.md
Name: prog_xbar

Overview:
- Parametrised, glitch-free successor to the fixed-geometry routing crossbars.
- N_IN single-bit inputs route to N_OUT single-bit outputs; each output has an independent mux select loaded through the standard 32-bit daisy-chained programming shift chain.
- Configuration is double-buffered: shifting fills a shadow chain while the active configuration keeps routing; an explicit commit swaps it in atomically.
- Word-count checking flags incomplete programming; optional output register.

Parameters:
- N_IN, 32, number of routable inputs (2..255).
- N_OUT, 32, number of outputs (1..256).
- REG_OUT, 1, 1 = data_o registered (1-cycle latency), 0 = combinational.
- Derived, not overridable:
  - SEL_W = clog2(N_IN+1)
  - FPW = 32/SEL_W (floor), select fields per word
  - L = ceil(N_OUT/FPW), chain length in words

Ports:
- clk  in  1  system clock, all state on rising edge
- res  in  1  synchronous active-high reset
- prog_i  in  32  programming word from upstream chain
- prog_shft  in  1  shift enable
- prog_commit  in  1  single-cycle pulse, copy shadow to active
- prog_o  out  32  last shadow word (shadow[L-1]), to downstream chain
- cfg_ok  out  1  shadow holds ≥L freshly shifted words
- cfg_err  out  1  sticky: commit refused
- data_i  in  N_IN  routable inputs
- data_o  out  N_OUT  routed outputs

Behaviour:
- Reset (res=1 at clk edge), all cleared to 0: shadow[0..L-1], active[0..L-1], word counter cnt, cfg_err, data_o register. Thus prog_o=0, cfg_ok=0, data_o=0. Reset dominates shift and commit in the same cycle.
- Shift (prog_shft=1):
  - shadow[0]<=prog_i; shadow[k]<=shadow[k-1] for k=1..L-1.
  - cnt<=min(cnt+1, L), saturating.
  - active is untouched, so routing never glitches while shifting.
- cfg_ok = (cnt==L), combinational from cnt.
- Field mapping: output j uses active[j/FPW] bits [(j%FPW)*SEL_W +: SEL_W]. The last word shifted configures outputs 0..FPW-1. Unused upper bits of each word are ignored.
- Select decode: sel=0 → 0; sel=k, 1≤k≤N_IN → data_i[k-1]; sel>N_IN → 0 (no X).
- Commit (prog_commit=1 and prog_shft=0):
  - If cnt==L: active<=shadow, cnt<=0, cfg_err<=0.
  - Else: active unchanged, cnt unchanged, cfg_err<=1.
- Commit together with shift: the shift executes, the commit is refused, and cfg_err<=1.
- cfg_err is cleared only by reset or a successful commit.
- Over-shifting (daisy chain passing words through) keeps cnt at L. The retained shadow is the last L words.
- Latency:
  - REG_OUT=1: data_o(t+1) = route(active(t), data_i(t)). After a commit edge, the new routing appears on data_o one edge later.
  - REG_OUT=0: data_o follows data_i combinationally; new routing takes effect immediately after the commit edge.
- Reset mid-shift discards the partial shadow and returns cnt to 0.

Decomposition:
- Package xbar_pkg:
  - PROG_W=32
  - functions sel_w(n_in), fpw(sel_w), prog_len(n_out,fpw)
  - SEL_ZERO=0 constant
- Sub-module xbar_cfg_chain, parameter L: shadow shift chain, cnt, cfg_ok, cfg_err, active bank, commit logic. It exports the flat active vector.
- The top level holds the select decode/mux array and the optional output register.

Test Plan (defaults N_IN=N_OUT=32 → SEL_W=6, FPW=5, L=7; REG_OUT=1 unless stated):
- Reset:
  - Stimulus: hold res 2 cycles with data_i=FFFFFFFF.
  - Required: data_o=0, prog_o=0, cfg_ok=0, cfg_err=0.
- Basic route:
  - Stimulus: shift 7 words, last word=0x00000004 (output0 sel=4), others 0; commit; drive data_i=0x00000008.
  - Required: cfg_ok=1 before commit; data_o=0x00000001 one cycle after the commit edge, and 0 before it.
- Short program:
  - Stimulus: shift 5 words, commit.
  - Required: cfg_err=1, prior routing still active, cfg_ok=0.
  - Follow-up: shift 2 more words, commit. Required: cfg_err=0, new routing active.
- Glitch-free reprogram:
  - Stimulus: with output0←input3 active, shift 7 new words routing output0←input5 while toggling data_i[2].
  - Required: data_o[0] tracks data_i[2] throughout shifting; tracks data_i[4] only after commit+1.
- Daisy chain / select boundaries:
  - Stimulus: shift 9 words W0..W8.
  - Required: prog_o shows W0 after shift 7 and W1 after shift 8; cnt stays 7. Select values 33 and 63 → output 0.
  - Same test with commit asserted together with prog_shft. Required: cfg_err=1, active unchanged.
- REG_OUT=0, N_IN=8, N_OUT=4 (SEL_W=4, FPW=8, L=1):
  - Stimulus: one word 0x00004321, commit.
  - Required: data_o[0..3] = data_i[0..3] combinationally, same cycle.
